// File: rtl/fetch_responder_if.sv
// fetch_responder_if: fetch request/response handshake between core and responder
interface fetch_responder_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        kill;
    logic        fetch_data_valid;
    logic [31:0] request_data;
    logic        fetch_fault;
    logic        resp_ready;
    modport master (
        output fetch_req, fetch_addr, kill, resp_ready,
        input  fetch_ready, fetch_data_valid, request_data, fetch_fault
    );
    modport slave (
        input  fetch_req, fetch_addr, kill, resp_ready,
        output fetch_ready, fetch_data_valid, request_data, fetch_fault
    );
endinterface

// File: rtl/fetch_responder.sv
// fetch_responder: in-order instruction fetch responder with fixed-latency read pipeline and response FIFO
module fetch_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 2,
    parameter int          QDEPTH    = 4,
    parameter logic [31:0] NOP_INST  = 32'h00000013
) (
    input  logic                         clk,
    input  logic                         rst,
    fetch_responder_if.slave             fif,
    input  logic                         prog_we,
    input  logic [$clog2(MEM_WORDS)-1:0] prog_addr,
    input  logic [31:0]                  prog_data
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]   mem [MEM_WORDS];
    logic [32:0]   fifo [QDEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, wa;
    logic [CW-1:0] fcnt_q, fcnt_d, ocnt_q, ocnt_d;
    logic          accept, pop, in_f, push_v;
    logic [32:0]   in_e, push_e;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(QDEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign accept = fif.fetch_req && fif.fetch_ready;
    assign pop    = fif.fetch_data_valid && fif.resp_ready;
    assign in_f   = fif.fetch_addr[1:0] != 2'b00 || fif.fetch_addr[31:2] >= 30'(MEM_WORDS);
    assign in_e   = {in_f, in_f ? NOP_INST : mem[fif.fetch_addr[AW+1:2]]};

    // Capacity is reserved at accept, so the pipeline never has to stall.
    assign fif.fetch_ready      = ocnt_q < CW'(QDEPTH);
    assign fif.fetch_data_valid = fcnt_q != '0;
    assign fif.request_data     = fif.fetch_data_valid ? fifo[rd_q][31:0] : 32'd0;
    assign fif.fetch_fault      = fif.fetch_data_valid && fifo[rd_q][32];

    // The last pipeline stage is the FIFO write itself, giving LATENCY cycles accept-to-valid.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_v = accept;
            assign push_e = in_e;
        end else begin : g_pipe
            logic [LATENCY-2:0] v_q, v_d;
            logic [32:0]        pipe_e [LATENCY-1];
            // Shift valid bits; kill drops every older entry but keeps this cycle's accept
            always_comb begin
                v_d    = '0;
                v_d[0] = accept;
                for (int i = 1; i < LATENCY - 1; i++) v_d[i] = v_q[i-1] && !fif.kill;
            end
            // Valid bit register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) v_q <= '0;
                else     v_q <= v_d;
            end
            // Payload stages are qualified by the valid bits and need no reset
            always_ff @(posedge clk) begin
                pipe_e[0] <= in_e;
                for (int i = 1; i < LATENCY - 1; i++) pipe_e[i] <= pipe_e[i-1];
            end
            assign push_v = v_q[LATENCY-2] && !fif.kill;
            assign push_e = pipe_e[LATENCY-2];
        end
    endgenerate

    assign wa = fif.kill ? '0 : wr_q;

    // FIFO pointers and outstanding count; kill empties everything except a same-cycle push
    always_comb begin
        rd_d   = pop ? nxt(rd_q) : rd_q;
        wr_d   = push_v ? nxt(wr_q) : wr_q;
        fcnt_d = fcnt_q + CW'(push_v) - CW'(pop);
        ocnt_d = ocnt_q + CW'(accept) - CW'(pop);
        if (fif.kill) begin
            rd_d   = '0;
            wr_d   = push_v ? nxt('0) : '0;
            fcnt_d = CW'(push_v);
            ocnt_d = CW'(accept);
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            fcnt_q <= '0;
            ocnt_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            fcnt_q <= fcnt_d;
            ocnt_q <= ocnt_d;
        end
    end

    // Instruction array load and FIFO storage; a same-edge fetch read sees the old word
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_data;
        if (push_v)  fifo[wa] <= push_e;
    end
endmodule

// File: tb/tb_fetch_responder.sv
// tb_fetch_responder: directed stimulus with a queue scoreboard and an independent response monitor
module tb_fetch_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [9:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    int          errors = 0;
    int          checks = 0;
    logic [32:0] exp_q[$];
    bit          armed = 1'b0;
    longint      t_first = -1, t_last = -1, t_acc = 0, t0;
    int          w;

    fetch_responder_if fif();

    fetch_responder #(.MEM_WORDS(1024), .LATENCY(2), .QDEPTH(4), .NOP_INST(32'h00000013)) dut (
        .clk(clk), .rst(rst), .fif(fif),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, got, want);
        end
    endtask

    // Monitor: every consumed response must match the scoreboard head
    always @(negedge clk) begin
        if (fif.fetch_data_valid && fif.resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got %h with no response expected", {fif.fetch_fault, fif.request_data});
            end else chk("resp", {fif.fetch_fault, fif.request_data}, exp_q.pop_front());
            if (armed) begin
                if (t_first < 0) t_first = $time;
                t_last = $time;
            end
        end else if (!fif.fetch_data_valid) chk("idle_zero", {fif.fetch_fault, fif.request_data}, 0);
    end

    task automatic load(input int a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = 10'(a); prog_data = d;
        @(posedge clk); #1 prog_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic f, input logic k, output int wt);
        fif.fetch_req = 1'b1; fif.fetch_addr = a; fif.kill = k; wt = 0;
        @(negedge clk);
        while (!fif.fetch_ready && wt < 40) begin
            wt++;
            @(negedge clk);
        end
        chk("accept_bound", fif.fetch_ready, 1);
        @(posedge clk);
        t_acc = $time;
        if (k) exp_q.delete();
        exp_q.push_back({f, d});
        #1 fif.fetch_req = 1'b0; fif.kill = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fif.fetch_req = 1'b0; fif.fetch_addr = '0; fif.kill = 1'b0; fif.resp_ready = 1'b1;
        @(negedge clk);
        chk("rst_valid", fif.fetch_data_valid, 0);
        chk("rst_data", fif.request_data, 0);
        chk("rst_fault", fif.fetch_fault, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", fif.fetch_ready, 1);
        @(posedge clk); #1;
        load(0, 32'h00100093);
        load(1, 32'h00200113);
        load(2, 32'h00308193);
        load(3, 32'h00410213);

        // back-to-back aligned fetches
        armed = 1'b1; t_first = -1;
        issue(32'h0, 32'h00100093, 1'b0, 1'b0, w); t0 = t_acc;
        issue(32'h4, 32'h00200113, 1'b0, 1'b0, w);
        issue(32'h8, 32'h00308193, 1'b0, 1'b0, w);
        issue(32'hC, 32'h00410213, 1'b0, 1'b0, w);
        drain();
        chk("first_latency", t_first - t0, 15);
        chk("burst_span", t_last - t_first, 30);
        armed = 1'b0;

        // misaligned and out-of-range fetches
        issue(32'h6, 32'h00000013, 1'b1, 1'b0, w);
        issue(32'h1000, 32'h00000013, 1'b1, 1'b0, w);
        drain();

        // backpressure fills to QDEPTH, head held stable
        fif.resp_ready = 1'b0;
        issue(32'h0, 32'h00100093, 1'b0, 1'b0, w);
        issue(32'h4, 32'h00200113, 1'b0, 1'b0, w);
        issue(32'h8, 32'h00308193, 1'b0, 1'b0, w);
        issue(32'hC, 32'h00410213, 1'b0, 1'b0, w);
        fif.fetch_req = 1'b1; fif.fetch_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", fif.fetch_ready, 0);
            chk("bp_head_valid", fif.fetch_data_valid, 1);
            chk("bp_head", fif.request_data, 32'h00100093);
        end
        @(posedge clk); #1 fif.resp_ready = 1'b1; armed = 1'b1; t_first = -1;
        issue(32'h0, 32'h00100093, 1'b0, 1'b0, w);
        chk("bp_resume_wait", w, 1);
        drain();
        chk("bp_pop_span", t_last - t_first, 40);
        armed = 1'b0;

        // kill with a redirected fetch in the same cycle
        fif.resp_ready = 1'b0;
        issue(32'h0, 32'h00100093, 1'b0, 1'b0, w);
        issue(32'h4, 32'h00200113, 1'b0, 1'b0, w);
        issue(32'hC, 32'h00410213, 1'b0, 1'b0, w);
        issue(32'h8, 32'h00308193, 1'b0, 1'b1, w); t0 = t_acc;
        fif.resp_ready = 1'b1; armed = 1'b1; t_first = -1;
        @(negedge clk);
        chk("kill_valid", fif.fetch_data_valid, 0);
        chk("kill_ready", fif.fetch_ready, 1);
        drain();
        chk("kill_latency", t_first - t0, 15);
        armed = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;

        // asynchronous reset mid-stream
        fif.resp_ready = 1'b0;
        issue(32'h0, 32'h00100093, 1'b0, 1'b0, w);
        issue(32'h4, 32'h00200113, 1'b0, 1'b0, w);
        #2 rst = 1'b1;
        #1 chk("rst_async_valid", fif.fetch_data_valid, 0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0; fif.resp_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", fif.fetch_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_stale", fif.fetch_data_valid, 0);
        end
        @(posedge clk); #1;

        // program write colliding with a fetch of the same word
        prog_we = 1'b1; prog_addr = 10'd2; prog_data = 32'hDEADBEEF;
        issue(32'h8, 32'h00308193, 1'b0, 1'b0, w);
        prog_we = 1'b0;
        issue(32'h8, 32'hDEADBEEF, 1'b0, 1'b0, w);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
